// File: rtl/banff_decode_pkg.sv
// ============================================================================
// banff_decode_pkg : RV32I opcodes, op-class encodings, immediate formats
// Rev 1.0
// ============================================================================
`default_nettype none

package banff_decode_pkg;

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] C_CLS_LUI     = 4'd0;
  localparam logic [3:0] C_CLS_AUIPC   = 4'd1;
  localparam logic [3:0] C_CLS_JAL     = 4'd2;
  localparam logic [3:0] C_CLS_JALR    = 4'd3;
  localparam logic [3:0] C_CLS_BRANCH  = 4'd4;
  localparam logic [3:0] C_CLS_LOAD    = 4'd5;
  localparam logic [3:0] C_CLS_STORE   = 4'd6;
  localparam logic [3:0] C_CLS_OPIMM   = 4'd7;
  localparam logic [3:0] C_CLS_OP      = 4'd8;
  localparam logic [3:0] C_CLS_FENCE   = 4'd9;
  localparam logic [3:0] C_CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] C_CLS_ILLEGAL = 4'd15;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

`default_nettype wire

// File: rtl/decode_issue_imm_gen.sv
// ============================================================================
// imm_gen : combinational RV32I immediate extractor, sign-extended to XLEN
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen
  import banff_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
);

  imm_fmt_e    w_fmt;
  logic [31:0] w_imm32;

  always_comb begin
    w_fmt = IMM_NONE;
    case (instr_i[6:0])
      C_OPC_JALR, C_OPC_LOAD, C_OPC_OPIMM, C_OPC_SYSTEM: w_fmt = IMM_I;
      C_OPC_STORE:                                       w_fmt = IMM_S;
      C_OPC_BRANCH:                                      w_fmt = IMM_B;
      C_OPC_LUI, C_OPC_AUIPC:                            w_fmt = IMM_U;
      C_OPC_JAL:                                         w_fmt = IMM_J;
      default:                                           w_fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      IMM_I: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: w_imm32 = {instr_i[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(w_imm32));
  assign fmt_o = w_fmt;

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// ============================================================================
// decode_issue : single-entry RV32I decode register with RAW scoreboard/issue
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_issue
  import banff_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OPC_W      = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [31:0]           if_instr_i,
  input  logic [XLEN-1:0]       if_pc_i,
  output logic                  rf_re_o,
  output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  flush_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [XLEN-1:0]       id_pc_o,
  output logic [OPC_W-1:0]      id_op_o,
  output logic [2:0]            id_funct3_o,
  output logic                  id_funct7b5_o,
  output logic [REG_ADDR_W-1:0] id_rd_o,
  output logic                  id_rd_we_o,
  output logic [XLEN-1:0]       id_imm_o,
  output logic                  id_illegal_o
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic                  d_valid_q;
  logic [31:0]           d_instr_q;
  logic [XLEN-1:0]       d_pc_q;
  logic [NREG-1:0]       busy_q, busy_d;

  logic [OPC_W-1:0]      w_op;
  logic                  w_rs1_used, w_rs2_used, w_rd_we_cls, w_rd_we;
  logic                  w_hazard, w_issue, w_if_fire;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]       w_imm_raw, w_imm;
  logic [2:0]            w_fmt;

  assign w_rs1 = d_instr_q[15 +: REG_ADDR_W];
  assign w_rs2 = d_instr_q[20 +: REG_ADDR_W];
  assign w_rd  = d_instr_q[7 +: REG_ADDR_W];

  always_comb begin
    w_op = C_CLS_ILLEGAL;
    case (d_instr_q[6:0])
      C_OPC_LUI:    w_op = C_CLS_LUI;
      C_OPC_AUIPC:  w_op = C_CLS_AUIPC;
      C_OPC_JAL:    w_op = C_CLS_JAL;
      C_OPC_JALR:   w_op = C_CLS_JALR;
      C_OPC_BRANCH: w_op = C_CLS_BRANCH;
      C_OPC_LOAD:   w_op = C_CLS_LOAD;
      C_OPC_STORE:  w_op = C_CLS_STORE;
      C_OPC_OPIMM:  w_op = C_CLS_OPIMM;
      C_OPC_OP:     w_op = C_CLS_OP;
      C_OPC_FENCE:  w_op = C_CLS_FENCE;
      C_OPC_SYSTEM: w_op = C_CLS_SYSTEM;
      default:      w_op = C_CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    w_rs1_used  = 1'b0;
    w_rs2_used  = 1'b0;
    w_rd_we_cls = 1'b0;
    case (w_op)
      C_CLS_LUI, C_CLS_AUIPC, C_CLS_JAL, C_CLS_SYSTEM: w_rd_we_cls = 1'b1;
      C_CLS_JALR, C_CLS_LOAD, C_CLS_OPIMM: begin
        w_rs1_used  = 1'b1;
        w_rd_we_cls = 1'b1;
      end
      C_CLS_BRANCH, C_CLS_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      C_CLS_OP: begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
        w_rd_we_cls = 1'b1;
      end
      default: ;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (d_instr_q),
    .imm_o   (w_imm_raw),
    .fmt_o   (w_fmt)
  );

  // OP, FENCE and illegal encodings carry no immediate
  assign w_imm   = (w_fmt == 3'(IMM_NONE)) ? '0 : w_imm_raw;
  assign w_rd_we = w_rd_we_cls && (w_rd != '0);

  // busy[0] is always 0, so x0 sources never stall
  assign w_hazard  = (w_rs1_used && busy_q[w_rs1]) || (w_rs2_used && busy_q[w_rs2]);
  assign w_issue   = d_valid_q && !w_hazard && !flush_i && (!id_valid_o || id_ready_i);
  assign if_ready_o = !flush_i && (!d_valid_q || w_issue);
  assign w_if_fire = if_valid_i && if_ready_o;

  assign rf_re_o       = w_issue;
  assign rf_rs1_addr_o = w_rs1;
  assign rf_rs2_addr_o = w_rs2;

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      d_valid_q <= 1'b0;
    end else if (w_if_fire) begin
      d_valid_q <= 1'b1;
    end else if (w_issue) begin
      d_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_if_fire) begin
      d_instr_q <= if_instr_i;
      d_pc_q    <= if_pc_i;
    end
  end

  // Set after clear so an issue targeting the retiring rd keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
    if (w_issue && w_rd_we) busy_d[w_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) busy_q <= '0;
    else                    busy_q <= busy_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      id_valid_o    <= 1'b0;
      id_pc_o       <= '0;
      id_op_o       <= '0;
      id_funct3_o   <= '0;
      id_funct7b5_o <= 1'b0;
      id_rd_o       <= '0;
      id_rd_we_o    <= 1'b0;
      id_imm_o      <= '0;
      id_illegal_o  <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (w_issue) begin
      id_valid_o    <= 1'b1;
      id_pc_o       <= d_pc_q;
      id_op_o       <= w_op;
      id_funct3_o   <= d_instr_q[14:12];
      id_funct7b5_o <= d_instr_q[30];
      id_rd_o       <= w_rd;
      id_rd_we_o    <= w_rd_we;
      id_imm_o      <= w_imm;
      id_illegal_o  <= (w_op == C_CLS_ILLEGAL);
    end else if (id_ready_i) begin
      id_valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// ============================================================================
// tb_decode_issue : directed stimulus with a queue scoreboard on the id_* port
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_issue;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, if_valid, wb_valid, flush, id_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  wb_rd;
  logic        if_ready_o, rf_re_o, id_valid_o, id_funct7b5_o, id_rd_we_o, id_illegal_o;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o, id_rd_o;
  logic [31:0] id_pc_o, id_imm_o;
  logic [3:0]  id_op_o;
  logic [2:0]  id_funct3_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  decode_issue dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .if_valid_i    (if_valid),
    .if_ready_o    (if_ready_o),
    .if_instr_i    (if_instr),
    .if_pc_i       (if_pc),
    .rf_re_o       (rf_re_o),
    .rf_rs1_addr_o (rf_rs1_addr_o),
    .rf_rs2_addr_o (rf_rs2_addr_o),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .flush_i       (flush),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc_o),
    .id_op_o       (id_op_o),
    .id_funct3_o   (id_funct3_o),
    .id_funct7b5_o (id_funct7b5_o),
    .id_rd_o       (id_rd_o),
    .id_rd_we_o    (id_rd_we_o),
    .id_imm_o      (id_imm_o),
    .id_illegal_o  (id_illegal_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] op, input logic [2:0] f3,
                              input logic f7b5, input logic [4:0] rd, input logic we,
                              input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = pc; e.op = op; e.f3 = f3; e.f7b5 = f7b5;
    e.rd = rd; e.we = we; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    bit ok = 1'b0;
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clock);
      if (if_ready_o) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout pc=%0h if_ready=%0b expected=1", pc, if_ready_o);
    end
    step();
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; id_ready = 1'b1;

    fork
      begin : monitor
        exp_t got, e;
        forever begin
          @(negedge clock);
          if (!reset && id_valid_o && id_ready) begin
            got = {id_pc_o, id_op_o, id_funct3_o, id_funct7b5_o, id_rd_o,
                   id_rd_we_o, id_imm_o, id_illegal_o};
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_issue actual=%0h expected=none", got);
            end else begin
              e = exp_q.pop_front();
              chk("issue", 128'(got), 128'(e));
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_id_valid", 128'(id_valid_o), 128'(0));
    chk("rst_if_ready", 128'(if_ready_o), 128'(1));
    chk("rst_rf_re",    128'(rf_re_o),    128'(0));
    chk("rst_fields",   128'({id_pc_o, id_op_o, id_imm_o, id_illegal_o, id_rd_we_o}), 128'(0));
    chk("rst_busy",     128'(dut.busy_q), 128'(0));
    step();

    // ADDI x1,x0,5
    exp_q.push_back(mk(32'h100, 4'd7, 3'd0, 1'b0, 5'd1, 1'b1, 32'd5, 1'b0));
    fetch(32'h00500093, 32'h100);
    @(negedge clock);
    chk("lat_id_valid_early", 128'(id_valid_o), 128'(0));
    chk("lat_rf_re",          128'(rf_re_o),    128'(1));
    @(negedge clock);
    chk("lat_id_valid",       128'(id_valid_o), 128'(1));
    chk("busy1_set",          128'(dut.busy_q[1]), 128'(1));
    step();
    wb(5'd1);

    // ADDI x1 then ADD x2,x1,x1: RAW stall until the cycle after writeback
    exp_q.push_back(mk(32'h200, 4'd7, 3'd0, 1'b0, 5'd1, 1'b1, 32'd5, 1'b0));
    exp_q.push_back(mk(32'h204, 4'd8, 3'd0, 1'b0, 5'd2, 1'b1, 32'd0, 1'b0));
    fetch(32'h00500093, 32'h200);
    fetch(32'h00108133, 32'h204);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_rf_re",    128'(rf_re_o),    128'(0));
      chk("stall_if_ready", 128'(if_ready_o), 128'(0));
    end
    chk("stall_rs_addr", 128'({rf_rs1_addr_o, rf_rs2_addr_o}), 128'({5'd1, 5'd1}));
    step();
    wb_valid = 1'b1; wb_rd = 5'd1;
    @(negedge clock);
    chk("wb_no_bypass", 128'(rf_re_o), 128'(0));
    step();
    wb_valid = 1'b0;
    @(negedge clock);
    chk("stall_release_rf_re",    128'(rf_re_o),    128'(1));
    chk("stall_release_if_ready", 128'(if_ready_o), 128'(1));
    repeat (3) step();

    // Back-pressure: LUI held on id_*, AUIPC waits in decode, JAL blocked
    id_ready = 1'b0;
    exp_q.push_back(mk(32'h300, 4'd0, 3'd5, 1'b0, 5'd5, 1'b1, 32'h12345000, 1'b0));
    exp_q.push_back(mk(32'h304, 4'd1, 3'd1, 1'b0, 5'd6, 1'b1, 32'h00001000, 1'b0));
    exp_q.push_back(mk(32'h308, 4'd2, 3'd0, 1'b0, 5'd0, 1'b0, 32'd8, 1'b0));
    fetch(32'h123452B7, 32'h300);
    fetch(32'h00001317, 32'h304);
    if_valid = 1'b1; if_instr = 32'h0080006F; if_pc = 32'h308;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_id_valid", 128'(id_valid_o), 128'(1));
      chk("hold_id_pc",    128'(id_pc_o),    128'(32'h300));
      chk("hold_id_imm",   128'(id_imm_o),   128'(32'h12345000));
      chk("hold_if_ready", 128'(if_ready_o), 128'(0));
    end
    chk("hold_d_valid", 128'(dut.d_valid_q), 128'(1));
    step();
    id_ready = 1'b1;
    @(negedge clock);
    chk("release_if_ready", 128'(if_ready_o), 128'(1));
    step();
    if_valid = 1'b0;
    repeat (3) step();
    wb(5'd2); wb(5'd5); wb(5'd6);
    @(negedge clock);
    chk("busy_drained", 128'(dut.busy_q), 128'(0));
    step();

    // SW x5,-4(x2)
    exp_q.push_back(mk(32'h400, 4'd6, 3'd2, 1'b1, 5'd28, 1'b0, 32'hFFFFFFFC, 1'b0));
    fetch(32'hFE512E23, 32'h400);
    repeat (3) step();
    chk("sw_busy_unchanged", 128'(dut.busy_q), 128'(0));

    // Flush while stalled on busy[3], with a writeback in the flush cycle
    exp_q.push_back(mk(32'h500, 4'd7, 3'd0, 1'b0, 5'd3, 1'b1, 32'd1, 1'b0));
    fetch(32'h00100193, 32'h500);
    fetch(32'h00018233, 32'h504);
    @(negedge clock);
    chk("pre_flush_stall", 128'(rf_re_o), 128'(0));
    step();
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clock);
    chk("flush_if_ready", 128'(if_ready_o), 128'(0));
    step();
    flush = 1'b0; wb_valid = 1'b0;
    @(negedge clock);
    chk("post_flush_id_valid", 128'(id_valid_o),    128'(0));
    chk("post_flush_d_valid",  128'(dut.d_valid_q), 128'(0));
    chk("post_flush_busy",     128'(dut.busy_q),    128'(0));
    chk("post_flush_if_ready", 128'(if_ready_o),    128'(1));
    step();

    // Illegal zero word, then ADDI x0,x0,0
    exp_q.push_back(mk(32'h600, 4'd15, 3'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1));
    exp_q.push_back(mk(32'h604, 4'd7,  3'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0));
    fetch(32'h00000000, 32'h600);
    fetch(32'h00000013, 32'h604);
    repeat (3) step();
    chk("nop_busy", 128'(dut.busy_q), 128'(0));

    // Reset while an op is held on id_* under back-pressure
    id_ready = 1'b0;
    fetch(32'h000013B7, 32'h700);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_id_valid", 128'(id_valid_o),    128'(0));
    chk("midrst_id_pc",    128'(id_pc_o),       128'(0));
    chk("midrst_d_valid",  128'(dut.d_valid_q), 128'(0));
    chk("midrst_busy",     128'(dut.busy_q),    128'(0));
    chk("midrst_if_ready", 128'(if_ready_o),    128'(1));
    id_ready = 1'b1;
    repeat (3) step();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
